// File: rtl/lookahead_divider.sv
// 8-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// Each trial subtraction is a 9-bit carry-lookahead add of the shifted remainder and ~divisor.
module lookahead_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [2:0] cnt;
  logic [8:0] r;
  logic [7:0] a, b, qw;

  logic [8:0] t, y, g, p, diff;
  logic [9:0] c;
  logic       cout;

  // t - divisor as t + ~divisor + 1; carry-out set means t >= divisor
  always_comb begin
    t    = {r[7:0], a[3'd7 - cnt]};
    y    = ~{1'b0, b};
    g    = t & y;
    p    = t ^ y;
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < 9; i++) c[i+1] = g[i] | (p[i] & c[i]);
    diff = p ^ c[8:0];
    cout = c[9];
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      r           <= '0;
      a           <= '0;
      b           <= '0;
      qw          <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a   <= dividend;
            b   <= divisor;
            r   <= '0;
            cnt <= '0;
            qw  <= '0;
            if (divisor == 8'd0) begin
              quotient    <= 8'hFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          r   <= cout ? diff : t;
          qw  <= {qw[6:0], cout};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            quotient    <= {qw[6:0], cout};
            remainder   <= cout ? diff[7:0] : t[7:0];
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
